// File: rtl/win_ctrl_if.sv
// vga_if: VGA timing bundle passed between pipeline stages.
// win_ctrl only reads vblnk through the "in" modport; the other
// members are carried for the rest of the VGA pipeline.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in (
        input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

    modport out (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );
endinterface

// File: rtl/win_ctrl.sv
// win_ctrl: game-result controller for the win-screen overlay.
//
// Watches piece counts and no-legal-move flags. A result must hold for
// CONFIRM_FRAMES consecutive frame ticks before it is latched. Then it is
// shown on white_win/black_win until a restart, and after that a one-cycle
// new_game pulse is issued. All output changes happen on the edge that ends a
// frame-tick cycle, which is at vblank start, so the overlay never tears.
//
// Optional feature macro: WIN_AUTO_RESTART_EN
//   defined   - SHOW also ends by itself after WIN_FRAMES frame ticks.
//   undefined - SHOW is held until a restart_btn rising edge.
module win_ctrl #(
    parameter int PIECE_W        = 5,
    parameter int CONFIRM_FRAMES = 2,
    parameter int WIN_FRAMES     = 300
) (
    input  logic               clk,
    input  logic               rst,
    vga_if.in                  vga_in,
    input  logic [PIECE_W-1:0] white_cnt,
    input  logic [PIECE_W-1:0] black_cnt,
    input  logic               white_stuck,
    input  logic               black_stuck,
    input  logic               turn,
    input  logic               restart_btn,
    output logic               white_win,
    output logic               black_win,
    output logic               game_over,
    output logic               new_game
);

    // Reject parameter values that make the confirm or hold windows empty.
    if (CONFIRM_FRAMES < 1 || WIN_FRAMES < 1) begin : g_param_check
        $error("win_ctrl: CONFIRM_FRAMES and WIN_FRAMES must both be >= 1");
    end

    localparam int CONF_W = $clog2(CONFIRM_FRAMES + 1);
    localparam logic [CONF_W-1:0] CONF_MAX  = CONF_W'(CONFIRM_FRAMES);
    localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONFIRM_FRAMES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PLAY    = 3'd1,
        CONFIRM = 3'd2,
        SHOW    = 3'd3,
        CLEAR   = 3'd4
    } state_t;

    state_t              state;
    logic                vblnk_d;
    logic                btn_d;
    logic                held_white;   // stored candidate: 1 = white, 0 = black
    logic [CONF_W-1:0]   conf_cnt;

    logic                frame_tick;
    logic                btn_rise;
    logic                w_cond;
    logic                b_cond;
    logic                cand_valid;
    logic                cand_white;

`ifdef WIN_AUTO_RESTART_EN
    localparam int SHOW_W = $clog2(WIN_FRAMES + 1);
    localparam logic [SHOW_W-1:0] SHOW_MAX  = SHOW_W'(WIN_FRAMES);
    localparam logic [SHOW_W-1:0] SHOW_LAST = SHOW_W'(WIN_FRAMES - 1);

    logic [SHOW_W-1:0]   show_cnt;

    // Saturating increment for the win-screen hold counter.
    function automatic logic [SHOW_W-1:0] show_inc(input logic [SHOW_W-1:0] v);
        return (v == SHOW_MAX) ? v : v + 1'b1;
    endfunction
`endif

    // Saturating increment for the confirmation counter.
    function automatic logic [CONF_W-1:0] conf_inc(input logic [CONF_W-1:0] v);
        return (v == CONF_MAX) ? v : v + 1'b1;
    endfunction

    // Frame tick, restart edge and the candidate result for this cycle.
    always_comb begin
        frame_tick = vga_in.vblnk & ~vblnk_d;
        btn_rise   = restart_btn & ~btn_d;
        w_cond     = (black_cnt == '0) | (turn & black_stuck);
        b_cond     = (white_cnt == '0) | (~turn & white_stuck);
        // Both sides winning at once is treated as no result.
        cand_valid = w_cond ^ b_cond;
        cand_white = w_cond;
    end

    // Edge-detector history: updated every cycle regardless of FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_d <= 1'b0;
            btn_d   <= 1'b0;
        end else begin
            vblnk_d <= vga_in.vblnk;
            btn_d   <= restart_btn;
        end
    end

    // Result FSM with registered overlay outputs and new_game pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            held_white <= 1'b0;
            conf_cnt   <= '0;
            white_win  <= 1'b0;
            black_win  <= 1'b0;
            game_over  <= 1'b0;
            new_game   <= 1'b0;
`ifdef WIN_AUTO_RESTART_EN
            show_cnt   <= '0;
`endif
        end else begin
            new_game <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_tick) begin
                        state <= PLAY;
                    end
                end

                PLAY: begin
                    if (frame_tick && cand_valid) begin
                        held_white <= cand_white;
                        conf_cnt   <= CONF_W'(1);
                        if (CONFIRM_FRAMES == 1) begin
                            // A single tick is enough: latch the result now.
                            state     <= SHOW;
                            white_win <= cand_white;
                            black_win <= ~cand_white;
                            game_over <= 1'b1;
`ifdef WIN_AUTO_RESTART_EN
                            show_cnt  <= '0;
`endif
                        end else begin
                            state <= CONFIRM;
                        end
                    end
                end

                CONFIRM: begin
                    if (frame_tick) begin
                        if (cand_valid && (cand_white == held_white)) begin
                            conf_cnt <= conf_inc(conf_cnt);
                            if (conf_cnt >= CONF_LAST) begin
                                state     <= SHOW;
                                white_win <= held_white;
                                black_win <= ~held_white;
                                game_over <= 1'b1;
`ifdef WIN_AUTO_RESTART_EN
                                show_cnt  <= '0;
`endif
                            end
                        end else begin
                            // Only the value at the tick matters; any change restarts.
                            conf_cnt <= '0;
                            state    <= PLAY;
                        end
                    end
                end

                SHOW: begin
                    // Leaving SHOW never touches outputs; CLEAR drops them on a tick.
                    if (btn_rise) begin
                        state <= CLEAR;
                    end
`ifdef WIN_AUTO_RESTART_EN
                    else if (frame_tick) begin
                        if (show_cnt == SHOW_LAST) begin
                            state <= CLEAR;
                        end else begin
                            show_cnt <= show_inc(show_cnt);
                        end
                    end
`endif
                end

                CLEAR: begin
                    if (frame_tick) begin
                        white_win <= 1'b0;
                        black_win <= 1'b0;
                        game_over <= 1'b0;
                        new_game  <= 1'b1;
                        conf_cnt  <= '0;
`ifdef WIN_AUTO_RESTART_EN
                        show_cnt  <= '0;
`endif
                        state     <= PLAY;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_win_ctrl.sv
// tb_win_ctrl: directed, table-driven bench for win_ctrl
// (CONFIRM_FRAMES = 2, WIN_FRAMES = 3).
module tb_win_ctrl;
    localparam int PW = 5;
    localparam int CF = 2;
    localparam int WF = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] white_cnt, black_cnt;
    logic          white_stuck, black_stuck, turn, restart_btn;
    logic          white_win, black_win, game_over, new_game;

    int checks = 0;
    int errors = 0;

    vga_if vga ();

    always #5 clk = ~clk;

    win_ctrl #(.PIECE_W(PW), .CONFIRM_FRAMES(CF), .WIN_FRAMES(WF)) dut (
        .clk(clk), .rst(rst), .vga_in(vga),
        .white_cnt(white_cnt), .black_cnt(black_cnt),
        .white_stuck(white_stuck), .black_stuck(black_stuck),
        .turn(turn), .restart_btn(restart_btn),
        .white_win(white_win), .black_win(black_win),
        .game_over(game_over), .new_game(new_game)
    );

    typedef struct {
        logic [PW-1:0] wc, bc;
        logic          ws, bs, tn;
        int            btn;   // 0 none, 1 pulse mid-frame, 2 rise in tick cycle
        int            reps;
        logic          ew, eb, eg;
        int            eng;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [PW-1:0] wc, input logic [PW-1:0] bc,
                          input logic ws, input logic bs, input logic tn);
        white_cnt = wc; black_cnt = bc;
        white_stuck = ws; black_stuck = bs; turn = tn;
    endtask

    // One frame: 4 cycles vblnk low, 2 high. Outputs may only change on the
    // edge that ends the first vblnk-high cycle.
    task automatic run_frame(input int btn_mode, output int ng, output int glitches);
        logic [2:0] prev;
        ng = 0; glitches = 0;
        prev = {white_win, black_win, game_over};
        for (int i = 0; i < 4; i++) begin
            if (btn_mode == 1) restart_btn = (i == 1 || i == 2);
            @(posedge clk); #1;
            if ({white_win, black_win, game_over} != prev) glitches++;
            if (new_game) ng++;
        end
        restart_btn = (btn_mode == 2);
        vga.vblnk = 1'b1;
        @(posedge clk); #1;
        if (new_game) ng++;
        prev = {white_win, black_win, game_over};
        restart_btn = 1'b0;
        @(posedge clk); #1;
        if ({white_win, black_win, game_over} != prev) glitches++;
        if (new_game) ng++;
        vga.vblnk = 1'b0;
    endtask

    task automatic frame_check(input string tag, input int btn_mode,
                               input logic ew, input logic eb, input logic eg, input int eng);
        int ng, gl;
        run_frame(btn_mode, ng, gl);
        check({tag, ".white_win"}, int'(white_win), int'(ew));
        check({tag, ".black_win"}, int'(black_win), int'(eb));
        check({tag, ".game_over"}, int'(game_over), int'(eg));
        check({tag, ".new_game_pulses"}, ng, eng);
        check({tag, ".mid_frame_changes"}, gl, 0);
    endtask

    initial begin
        int ng, gl, bad;
        vga.hcount = '0; vga.vcount = '0; vga.hsync = 1'b0; vga.vsync = 1'b0;
        vga.hblnk = 1'b0; vga.vblnk = 1'b0; vga.rgb = '0;
        restart_btn = 1'b0;
        set_in(12, 12, 0, 0, 0);

        // Each row: inputs held for one frame, outputs expected after its tick.
        //                  wc  bc  ws bs tn btn reps ew eb eg ng
        vecs.push_back(vec_t'{12, 12, 0, 0, 0, 0, 1,  0, 0, 0, 0}); // IDLE -> PLAY
        vecs.push_back(vec_t'{12, 12, 0, 0, 0, 1, 1,  0, 0, 0, 0}); // btn ignored in PLAY
        vecs.push_back(vec_t'{12, 12, 1, 0, 0, 0, 1,  0, 0, 0, 0}); // black cand -> CONFIRM
        vecs.push_back(vec_t'{12, 12, 0, 0, 0, 0, 1,  0, 0, 0, 0}); // stuck was one tick only
        vecs.push_back(vec_t'{12, 12, 1, 0, 1, 0, 1,  0, 0, 0, 0}); // white stuck on black's turn
        vecs.push_back(vec_t'{0,  0,  0, 0, 0, 0, 10, 0, 0, 0, 0}); // both zero: no result
        vecs.push_back(vec_t'{12, 12, 1, 0, 0, 0, 1,  0, 0, 0, 0}); // black cand -> CONFIRM
        vecs.push_back(vec_t'{12, 0,  0, 0, 0, 0, 1,  0, 0, 0, 0}); // cand changed -> PLAY
        vecs.push_back(vec_t'{12, 0,  0, 0, 0, 0, 1,  0, 0, 0, 0}); // white cand -> CONFIRM
        vecs.push_back(vec_t'{12, 0,  0, 0, 0, 0, 1,  1, 0, 1, 0}); // white latched
        vecs.push_back(vec_t'{12, 12, 0, 0, 0, 0, 1,  1, 0, 1, 0}); // held after cond gone
        vecs.push_back(vec_t'{12, 12, 0, 0, 0, 1, 1,  0, 0, 0, 1}); // restart -> clear on tick
        vecs.push_back(vec_t'{12, 12, 0, 1, 1, 0, 1,  0, 0, 0, 0}); // black stuck on its turn
        vecs.push_back(vec_t'{12, 12, 0, 1, 1, 0, 1,  1, 0, 1, 0}); // white latched
        vecs.push_back(vec_t'{12, 12, 0, 0, 0, 1, 1,  0, 0, 0, 1}); // restart
        vecs.push_back(vec_t'{0,  12, 0, 0, 0, 0, 1,  0, 0, 0, 0}); // white out of pieces
        vecs.push_back(vec_t'{0,  12, 0, 0, 0, 0, 1,  0, 1, 1, 0}); // black latched
        vecs.push_back(vec_t'{0,  12, 0, 0, 0, 0, 1,  0, 1, 1, 0}); // held
        vecs.push_back(vec_t'{12, 12, 0, 0, 0, 1, 1,  0, 0, 0, 1}); // restart
        vecs.push_back(vec_t'{12, 12, 0, 0, 0, 0, 1,  0, 0, 0, 0}); // back in PLAY

        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset.white_win", int'(white_win), 0);
        check("reset.black_win", int'(black_win), 0);
        check("reset.game_over", int'(game_over), 0);
        check("reset.new_game", int'(new_game), 0);
        rst = 1'b0;

        foreach (vecs[k]) begin
            for (int r = 0; r < vecs[k].reps; r++) begin
                set_in(vecs[k].wc, vecs[k].bc, vecs[k].ws, vecs[k].bs, vecs[k].tn);
                frame_check($sformatf("vec%0d_%0d", k, r), vecs[k].btn,
                            vecs[k].ew, vecs[k].eb, vecs[k].eg, vecs[k].eng);
            end
        end

        // Restart edge in the same cycle as the tick: drop one frame later.
        set_in(12, 0, 0, 0, 0);
        frame_check("samecyc.confirm", 0, 0, 0, 0, 0);
        frame_check("samecyc.show", 0, 1, 0, 1, 0);
        set_in(12, 12, 0, 0, 0);
        frame_check("samecyc.btn_tick", 2, 1, 0, 1, 0);
        frame_check("samecyc.drop", 0, 0, 0, 0, 1);

`ifdef WIN_AUTO_RESTART_EN
        // Auto restart: held for WIN_FRAMES ticks, dropped at the next one.
        set_in(12, 0, 0, 0, 0);
        frame_check("auto.confirm", 0, 0, 0, 0, 0);
        frame_check("auto.show", 0, 1, 0, 1, 0);
        set_in(12, 12, 0, 0, 0);
        frame_check("auto.hold1", 0, 1, 0, 1, 0);
        frame_check("auto.hold2", 0, 1, 0, 1, 0);
        frame_check("auto.hold3", 0, 1, 0, 1, 0);
        frame_check("auto.drop", 0, 0, 0, 0, 1);
        frame_check("auto.play", 0, 0, 0, 0, 0);
`else
        // No auto restart: 500 frames held, then a restart edge clears it.
        set_in(12, 0, 0, 0, 0);
        frame_check("hold.confirm", 0, 0, 0, 0, 0);
        frame_check("hold.show", 0, 1, 0, 1, 0);
        set_in(12, 12, 0, 0, 0);
        bad = 0;
        for (int f = 0; f < 500; f++) begin
            run_frame(0, ng, gl);
            if ({white_win, black_win, game_over} != 3'b101 || ng != 0 || gl != 0) bad++;
        end
        check("hold500.bad_frames", bad, 0);
        frame_check("hold.restart", 1, 0, 0, 0, 1);
`endif

        // Reset during SHOW: immediate clear, no new_game, back to IDLE.
        set_in(12, 0, 0, 0, 0);
        frame_check("rst.confirm", 0, 0, 0, 0, 0);
        frame_check("rst.show", 0, 1, 0, 1, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst.white_win", int'(white_win), 0);
        check("rst.game_over", int'(game_over), 0);
        check("rst.new_game", int'(new_game), 0);
        rst = 1'b0;
        frame_check("rst.idle_to_play", 0, 0, 0, 0, 0);
        frame_check("rst.confirm2", 0, 0, 0, 0, 0);
        frame_check("rst.show2", 0, 1, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/win_ctrl.md
# win_ctrl

Game-result controller that produces the `white_win` / `black_win` levels consumed by the win-screen overlay in the VGA pipeline. It watches piece counts and no-legal-move flags from the game logic and confirms a result over consecutive frames. It latches and holds the winner, changing outputs only on a frame boundary so the overlay never tears mid-frame. After the win screen it issues a one-cycle `new_game` pulse to restart the board.

## Interface
Parameters:
- `PIECE_W`, 5 — width of piece-count inputs.
- `CONFIRM_FRAMES`, 2 — consecutive frame ticks a win condition must hold before it is latched (≥1).
- `WIN_FRAMES`, 300 — frame ticks the win screen is held before auto-restart (≥1; used only with `WIN_AUTO_RESTART_EN`).

Ports:
- `clk`  in  1  pixel clock, shared with the VGA pipeline.
- `rst`  in  1  synchronous, active-high reset.
- `vga_in`  vga_if.in  —  timing bundle; only `vblnk` is used, and `rgb` is ignored.
- `white_cnt`  in  PIECE_W  white pieces remaining.
- `black_cnt`  in  PIECE_W  black pieces remaining.
- `white_stuck`  in  1  white has no legal move.
- `black_stuck`  in  1  black has no legal move.
- `turn`  in  1  side to move: 0 = white, 1 = black.
- `restart_btn`  in  1  debounced, clk-synchronous restart request (level).
- `white_win`  out  1  white has won; drives the overlay.
- `black_win`  out  1  black has won; drives the overlay.
- `game_over`  out  1  high while a result is held.
- `new_game`  out  1  one-cycle pulse telling game logic to reset the board.

## Operation
- Frame tick: `vblnk_d` is registered from `vga_in.vblnk`. `frame_tick = vga_in.vblnk & ~vblnk_d`, which asserts once per frame.
- Candidate result, evaluated combinationally:
  - `w_cond = (black_cnt == 0) | (turn & black_stuck)`
  - `b_cond = (white_cnt == 0) | (~turn & white_stuck)`
  - If both or neither are set, there is no candidate.
- FSM states: IDLE, PLAY, CONFIRM, SHOW, CLEAR.
  - IDLE: the reset state. Goes to PLAY on the first `frame_tick`.
  - PLAY: on a `frame_tick` with a candidate, store the candidate, set `conf_cnt = 1`, and go to CONFIRM. If `CONFIRM_FRAMES == 1`, go directly to SHOW.
  - CONFIRM: evaluated on each `frame_tick`.
    - Same candidate: increment `conf_cnt`. When it reaches `CONFIRM_FRAMES`, go to SHOW.
    - Candidate changed or absent: clear `conf_cnt` and return to PLAY.
    - Ticks where the candidate flips within the frame are ignored; only the value at the tick counts.
  - SHOW: assert the stored winner's output and `game_over`. `show_cnt` counts frame ticks from 0. Go to CLEAR on:
    - a rising edge of `restart_btn`, detected in any cycle; or
    - `show_cnt == WIN_FRAMES-1` at a tick (with the macro).
  - CLEAR: wait for the next `frame_tick`. On it, deassert all outputs, pulse `new_game` for that one cycle, clear the counters, and go to PLAY.
- `white_win` and `black_win` are never both high.
- `restart_btn` outside SHOW is ignored. Its edge detector is still updated every cycle.
- Counter widths are `$clog2(param+1)`. The counters saturate and never wrap.

## Timing
- All outputs are registered. Reset value of every output, counter, and `vblnk_d` is 0, and the state resets to IDLE.
- `rst` asserted mid-game (any state) returns to IDLE on the next edge. No `new_game` pulse is issued by reset.
- Win outputs and `game_over` change only on the edge that ends a `frame_tick` cycle. Because the tick is at vblank start, changes never occur inside the active area.
- Latency: a condition that is stable from before tick N is output after the edge ending tick N+CONFIRM_FRAMES-1.
- A `restart_btn` edge and a `frame_tick` in the same cycle: the FSM enters CLEAR, and outputs drop at the following tick (one full frame later).
- `new_game` is high for exactly one clk cycle, coincident with the outputs dropping.

## Configuration
- `WIN_AUTO_RESTART_EN` defined: SHOW exits after `WIN_FRAMES` ticks or on `restart_btn`, whichever comes first.
- Not defined: SHOW is held indefinitely until a `restart_btn` rising edge. `show_cnt` and `WIN_FRAMES` are unused.

## Test plan
- Reset, then `black_cnt = 0`, `CONFIRM_FRAMES = 2`: `white_win = 1` and `game_over = 1` after the edge of the 2nd tick. Never high between ticks.
- `turn = 0`, `white_stuck` pulsed for one tick only: stays in PLAY, `black_win` remains 0.
- `white_cnt = 0` and `black_cnt = 0` simultaneously: no win output for 10 frames.
- With the macro, `WIN_FRAMES = 3`: the win is held 3 ticks, then outputs go 0 at the following tick, `new_game` is high for exactly 1 cycle, and the FSM is back in PLAY.
- Without the macro: the win is held 500 frames. A `restart_btn` rise gives outputs 0 plus a `new_game` pulse at the next tick.
- `rst` asserted during SHOW: all outputs 0 on the next edge, no `new_game` pulse.
